// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared types and default sizing for the ALU slot arbiter
package alu_arb_pkg;

   localparam int DEF_N_REQ    = 4;
   localparam int DEF_HOLD_MAX = 30;
   localparam int DEF_DATA_W   = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } arb_state_t;

endpackage

// File: rtl/alu_slot_arbiter_rr_pick.sv
// rtl/alu_slot_arbiter_rr_pick.sv - combinational round-robin winner select
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  last_id,
   output logic             valid,
   output logic [ID_W-1:0]  win_id
);

   int idx;

   // Search starts one past the previous owner so it ends up lowest priority.
   always_comb begin
      valid  = 1'b0;
      win_id = '0;
      idx    = 0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = (int'(last_id) + k) % N_REQ;
         if (!valid && req[idx]) begin
            valid  = 1'b1;
            win_id = ID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/alu_slot_arbiter.sv
// rtl/alu_slot_arbiter.sv - round-robin owner arbiter for the shared ALU counter slot
module alu_slot_arbiter
   import alu_arb_pkg::*;
#(
   parameter int N_REQ    = DEF_N_REQ,
   parameter int HOLD_MAX = DEF_HOLD_MAX,
   parameter int DATA_W   = DEF_DATA_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_REQ-1:0]         req,
   output logic [N_REQ-1:0]         gnt,
   output logic [$clog2(N_REQ)-1:0] gnt_id,
   output logic                     busy,
   output logic [DATA_W-1:0]        hold_cnt,
   output logic                     timeout
);

   localparam int ID_W = $clog2(N_REQ);

   arb_state_t      state;
   logic [ID_W-1:0] last_id;
   logic            pick_valid;
   logic [ID_W-1:0] pick_id;

   rr_pick #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_rr_pick (
      .req     (req),
      .last_id (last_id),
      .valid   (pick_valid),
      .win_id  (pick_id)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         gnt      <= '0;
         gnt_id   <= '0;
         busy     <= 1'b0;
         hold_cnt <= '0;
         timeout  <= 1'b0;
         last_id  <= ID_W'(N_REQ - 1);
      end else begin
         case (state)
            IDLE: begin
               timeout  <= 1'b0;
               hold_cnt <= '0;
               if (pick_valid) begin
                  state   <= GRANT;
                  gnt     <= N_REQ'(1) << pick_id;
                  gnt_id  <= pick_id;
                  last_id <= pick_id;
                  busy    <= 1'b1;
               end
            end
            GRANT: begin
               timeout <= 1'b0;
               // An owner dropping req on the last allowed cycle is a normal release.
               if (!req[gnt_id]) begin
                  state    <= GAP;
                  gnt      <= '0;
                  busy     <= 1'b0;
                  hold_cnt <= '0;
               end else if (hold_cnt == DATA_W'(HOLD_MAX)) begin
                  state    <= GAP;
                  gnt      <= '0;
                  busy     <= 1'b0;
                  hold_cnt <= '0;
                  timeout  <= 1'b1;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            GAP: begin
               state   <= IDLE;
               timeout <= 1'b0;
            end
            default: begin
               state    <= IDLE;
               gnt      <= '0;
               busy     <= 1'b0;
               hold_cnt <= '0;
               timeout  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/alu_slot_arbiter.md
ALU_SLOT_ARBITER -- requirements
Module: alu_slot_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters sharing the ALU counter slot.
REQ-002 SHALL have parameter HOLD_MAX, default 30, last hold-count value before forced release.
REQ-003 SHALL have parameter DATA_W, default 8, width of hold_cnt.
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port req  input  N_REQ  per-requester level request, bit i = requester i.
REQ-007 SHALL have port gnt  output  N_REQ  registered one-hot grant, all-zero when no owner.
REQ-008 SHALL have port gnt_id  output  $clog2(N_REQ)  registered index of current or last owner.
REQ-009 SHALL have port busy  output  1  high while in GRANT state.
REQ-010 SHALL have port hold_cnt  output  DATA_W  cycles the current owner has held, counts 0..HOLD_MAX.
REQ-011 SHALL have port timeout  output  1  one-cycle pulse when an owner is force-released.

Function
REQ-012 SHALL implement FSM states IDLE, GRANT, GAP.
REQ-013 IDLE: if any req bit high, SHALL select winner by round robin starting at (last_id+1) mod N_REQ, go to GRANT; gnt/gnt_id/busy valid the next cycle (1-cycle req-to-gnt latency).
REQ-014 IDLE with req all-zero SHALL remain in IDLE, gnt=0, busy=0.
REQ-015 GRANT: hold_cnt SHALL be 0 on first grant cycle and increment by 1 each cycle while owner req stays high.
REQ-016 GRANT: owner req low SHALL cause release: next state GAP, gnt=0 next cycle, hold_cnt cleared to 0.
REQ-017 GRANT: hold_cnt==HOLD_MAX with owner req still high SHALL cause forced release to GAP and timeout=1 for exactly the cycle after hold_cnt==HOLD_MAX.
REQ-018 Owner req low in the same cycle hold_cnt==HOLD_MAX SHALL be a normal release; timeout SHALL stay 0.
REQ-019 Requests from non-owners during GRANT SHALL be ignored (no preemption).
REQ-020 GAP SHALL last exactly one cycle with gnt=0, busy=0, then go to IDLE.
REQ-021 last_id SHALL update to the winner index on entry to GRANT; gnt_id SHALL hold its value through GAP/IDLE.
REQ-022 A force-released owner SHALL become lowest priority via round robin; no extra penalty.
REQ-023 hold_cnt SHALL never exceed HOLD_MAX and SHALL be 0 outside GRANT.
REQ-024 gnt SHALL always be one-hot or zero; gnt[gnt_id]==busy.

Reset
REQ-025 rst_n low SHALL asynchronously force state=IDLE, gnt=0, gnt_id=0, busy=0, hold_cnt=0, timeout=0, last_id=N_REQ-1.
REQ-026 Reset asserted mid-GRANT SHALL drop gnt immediately; after release first arbitration SHALL favour requester 0.
REQ-027 No output SHALL change before the first rising clk edge after rst_n deassertion.

Structure
REQ-028 Package alu_arb_pkg SHALL hold the state enum (IDLE, GRANT, GAP) and default N_REQ, HOLD_MAX, DATA_W constants.
REQ-029 Round-robin selection SHALL be a combinational sub-module rr_pick (inputs req, last_id; outputs valid, win_id).
REQ-030 All outputs SHALL be driven directly from registers.

Verification
REQ-031 Reset, req=4'b0000 for 10 cycles -> gnt=0, busy=0, hold_cnt=0 throughout.
REQ-032 req=4'b1111 held -> grants in order 0,1,2,3,0; each grant lasts 31 cycles (hold_cnt 0..30), timeout pulse after each, 1-cycle GAP between.
REQ-033 req[2] high 5 cycles then low -> gnt=4'b0100 one cycle after req, hold_cnt reaches 4, release, timeout=0, GAP then IDLE.
REQ-034 Owner req[1] drops in cycle hold_cnt==30 -> normal release, timeout stays 0.
REQ-035 req[0] owning, req[3] rises at hold_cnt=10 -> gnt stays 4'b0001 until req[0] drops; gnt=4'b1000 two cycles later.
REQ-036 rst_n pulsed low at hold_cnt=15 with req=4'b0110 -> gnt=0 immediately; after release grant goes to requester 1.
